// File: rtl/lcd_hd44780_rx.sv
// rtl/lcd_hd44780_rx.sv - HD44780 4/8-bit write-bus receiver with 2x16 DDRAM image
// Optional busy timer and busy_err are compiled in with LCD_RX_BUSY_CHECK_EN.
module lcd_hd44780_rx #(
  parameter int unsigned MIN_E_HIGH   = 12,
  parameter int unsigned EXEC_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic [1:0] lcd_flags,
  input  logic [3:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       four_bit_mode,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_out,
  output logic       busy,
  output logic       short_pulse_err,
  output logic       busy_err
);

  localparam int CW = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] EMAX = CW'(MIN_E_HIGH);

  logic [1:0] flags_s1_q, flags_s2_q;
  logic [3:0] data_s1_q, data_s2_q;
  logic       e_d_q;
  logic [CW-1:0] ecnt_q, ecnt_d;
  logic       hold_rs_q, hold_rs_d;
  logic [3:0] hold_db_q, hold_db_d;
  logic       nib_ok_q, nib_ok_d, nib_rs_q, nib_rs_d;
  logic [3:0] nib_db_q, nib_db_d;
  logic       short_err_q, short_err_d;
  logic       phase_hi_q, phase_hi_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       four_bit_q, four_bit_d;
  logic       valid_q, valid_d, rs_q, rs_d;
  logic [7:0] out_q, out_d;
  logic [4:0] cursor_q, cursor_d;
  logic       id_q, id_d, disp_q, disp_d;
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  logic       e_s, e_fall;

  assign e_s    = flags_s2_q[0];
  assign e_fall = e_d_q & ~e_s;

  always_comb begin
    ecnt_d      = '0;
    hold_rs_d   = hold_rs_q;
    hold_db_d   = hold_db_q;
    nib_ok_d    = 1'b0;
    nib_rs_d    = nib_rs_q;
    nib_db_d    = nib_db_q;
    short_err_d = short_err_q;
    phase_hi_d  = phase_hi_q;
    hi_nib_d    = hi_nib_q;
    four_bit_d  = four_bit_q;
    valid_d     = 1'b0;
    rs_d        = rs_q;
    out_d       = out_q;
    cursor_d    = cursor_q;
    id_d        = id_q;
    disp_d      = disp_q;
    mem_d       = mem_q;

    // Track the last high-cycle bus values so the falling edge can use them.
    if (e_s) begin
      ecnt_d    = (ecnt_q == EMAX) ? ecnt_q : ecnt_q + 1'b1;
      hold_rs_d = flags_s2_q[1];
      hold_db_d = data_s2_q;
    end

    if (e_fall) begin
      if (ecnt_q < EMAX) begin
        short_err_d = 1'b1;
      end else begin
        nib_ok_d = 1'b1;
        nib_rs_d = hold_rs_q;
        nib_db_d = hold_db_q;
      end
    end

    if (nib_ok_q) begin
      if (!four_bit_q) begin
        valid_d = 1'b1;
        rs_d    = nib_rs_q;
        out_d   = {nib_db_q, 4'hF};
      end else if (phase_hi_q) begin
        hi_nib_d   = nib_db_q;
        phase_hi_d = 1'b0;
      end else begin
        valid_d    = 1'b1;
        rs_d       = nib_rs_q;
        out_d      = {hi_nib_q, nib_db_q};
        phase_hi_d = 1'b1;
      end
    end

    if (valid_q) begin
      if (rs_q) begin
        mem_d[cursor_q] = out_q;
        cursor_d        = id_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
      end else if (out_q[7]) begin
        cursor_d = {out_q[6], out_q[3:0]};
      end else if (out_q[6]) begin
        cursor_d = cursor_q;
      end else if (out_q[5]) begin
        four_bit_d = ~out_q[4];
        phase_hi_d = 1'b1;
      end else if (out_q[4]) begin
        cursor_d = cursor_q;
      end else if (out_q[3]) begin
        disp_d = out_q[2];
      end else if (out_q[2]) begin
        id_d = out_q[1];
      end else if (out_q[1]) begin
        cursor_d = 5'd0;
      end else if (out_q[0]) begin
        for (int i = 0; i < 32; i++) mem_d[i] = 8'h20;
        cursor_d = 5'd0;
        id_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_s1_q  <= '0;
      flags_s2_q  <= '0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      e_d_q       <= 1'b0;
      ecnt_q      <= '0;
      hold_rs_q   <= 1'b0;
      hold_db_q   <= '0;
      nib_ok_q    <= 1'b0;
      nib_rs_q    <= 1'b0;
      nib_db_q    <= '0;
      short_err_q <= 1'b0;
      phase_hi_q  <= 1'b1;
      hi_nib_q    <= '0;
      four_bit_q  <= 1'b0;
      valid_q     <= 1'b0;
      rs_q        <= 1'b0;
      out_q       <= 8'h00;
      cursor_q    <= 5'd0;
      id_q        <= 1'b1;
      disp_q      <= 1'b0;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else begin
      flags_s1_q  <= lcd_flags;
      flags_s2_q  <= flags_s1_q;
      data_s1_q   <= lcd_data;
      data_s2_q   <= data_s1_q;
      e_d_q       <= e_s;
      ecnt_q      <= ecnt_d;
      hold_rs_q   <= hold_rs_d;
      hold_db_q   <= hold_db_d;
      nib_ok_q    <= nib_ok_d;
      nib_rs_q    <= nib_rs_d;
      nib_db_q    <= nib_db_d;
      short_err_q <= short_err_d;
      phase_hi_q  <= phase_hi_d;
      hi_nib_q    <= hi_nib_d;
      four_bit_q  <= four_bit_d;
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      out_q       <= out_d;
      cursor_q    <= cursor_d;
      id_q        <= id_d;
      disp_q      <= disp_d;
      mem_q       <= mem_d;
    end
  end

`ifdef LCD_RX_BUSY_CHECK_EN
  localparam int BW = $clog2(CLEAR_CYCLES + 1);
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic          busy_err_q, busy_err_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    busy_err_d = busy_err_q;
    if (valid_q) begin
      if (busy_cnt_q != '0) busy_err_d = 1'b1;
      busy_cnt_d = (!rs_q && out_q >= 8'h01 && out_q <= 8'h03) ?
                   BW'(CLEAR_CYCLES) : BW'(EXEC_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= '0;
      busy_err_q <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      busy_err_q <= busy_err_d;
    end
  end

  assign busy     = (busy_cnt_q != '0);
  assign busy_err = busy_err_q;
`else
  logic unused_timing;
  assign unused_timing = EXEC_CYCLES[0] ^ CLEAR_CYCLES[0];
  assign busy     = 1'b0;
  assign busy_err = 1'b0;
`endif

  assign rd_char         = mem_q[rd_addr];
  assign cursor          = cursor_q;
  assign display_on      = disp_q;
  assign four_bit_mode   = four_bit_q;
  assign byte_valid      = valid_q;
  assign byte_rs         = rs_q;
  assign byte_out        = out_q;
  assign short_pulse_err = short_err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// tb/tb_lcd_hd44780_rx.sv - randomized self-checking bench for lcd_hd44780_rx
module tb_lcd_hd44780_rx;
  localparam int MIN_E = 12;
  localparam int EXEC  = 40;
  localparam int CLR   = 300;
`ifdef LCD_RX_BUSY_CHECK_EN
  localparam int GAP = CLR + 10;
`else
  localparam int GAP = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] lcd_flags = 2'b00;
  logic [3:0] lcd_data = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, byte_out;
  logic [4:0] cursor;
  logic display_on, four_bit_mode, byte_valid, byte_rs, busy, short_pulse_err, busy_err;

  lcd_hd44780_rx #(.MIN_E_HIGH(MIN_E), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)) dut (
    .qzt_clk(clk), .rst_n(rst_n), .lcd_flags(lcd_flags), .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor), .display_on(display_on),
    .four_bit_mode(four_bit_mode), .byte_valid(byte_valid), .byte_rs(byte_rs),
    .byte_out(byte_out), .busy(busy), .short_pulse_err(short_pulse_err),
    .busy_err(busy_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  logic last_busy = 1'b0;

  always @(negedge clk) if (rst_n && byte_valid) valid_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the LCD's visible state, updated one byte at a time.
  logic [7:0] m_ram [32];
  int  m_cur;
  bit  m_id, m_disp, m_four;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_cur = 0; m_id = 1; m_disp = 0; m_four = 0;
  endtask

  task automatic m_exec(input bit rs, input logic [7:0] b);
    int v;
    v = int'(b);
    if (rs) begin
      m_ram[m_cur] = b;
      m_cur = (m_cur + (m_id ? 1 : 31)) % 32;
    end else if (v == 1) begin
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_cur = 0; m_id = 1;
    end else if (v <= 3) m_cur = 0;
    else if (v <= 7)   m_id = b[1];
    else if (v <= 15)  m_disp = b[2];
    else if (v <= 31)  m_cur = m_cur;
    else if (v <= 63)  m_four = ~b[4];
    else if (v >= 128) m_cur = (b[6] ? 16 : 0) + (v % 16);
  endtask

  task automatic pulse(input bit rs, input logic [3:0] nib, input int hw);
    @(negedge clk);
    lcd_flags = {rs, 1'b1};
    lcd_data  = nib;
    repeat (hw) @(negedge clk);
    lcd_flags = {rs, 1'b0};
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input int gap);
    logic [7:0] eff;
    int lat;
    if (m_four) begin
      pulse(rs, b[7:4], $urandom_range(MIN_E + 4, MIN_E));
      repeat ($urandom_range(4, 2)) @(negedge clk);
      pulse(rs, b[3:0], $urandom_range(MIN_E + 4, MIN_E));
      eff = b;
    end else begin
      pulse(rs, b[7:4], $urandom_range(MIN_E + 4, MIN_E));
      eff = {b[7:4], 4'hF};
    end
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (byte_valid) begin
        lat = i;
        last_busy = busy;
        break;
      end
    end
    chk("latency", lat, 4);
    chk("byte_out", byte_out, eff);
    chk("byte_rs", byte_rs, rs);
    m_exec(rs, eff);
    repeat (2) @(negedge clk);
    chk("cursor", cursor, m_cur);
    chk("display_on", display_on, m_disp);
    chk("four_bit_mode", four_bit_mode, m_four);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      #1;
      chk($sformatf("ddram[%0d]", i), rd_char, m_ram[i]);
    end
  endtask

  task automatic read_at(input int a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rd_addr = 5'(a);
    #1;
    chk(tag, rd_char, exp);
  endtask

  initial begin
    #1900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [7:0] rb;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of an E pulse.
    @(negedge clk);
    lcd_flags = 2'b01; lcd_data = 4'h3;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cursor", cursor, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_four_bit", four_bit_mode, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_rs", byte_rs, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short_err", short_pulse_err, 0);
    chk("rst_busy_err", busy_err, 0);
    lcd_flags = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_ram();

    // Init sequence and first data write.
    send_byte(0, 8'h30, GAP);
    send_byte(0, 8'h30, GAP);
    send_byte(0, 8'h30, GAP);
    send_byte(0, 8'h20, GAP);
    send_byte(0, 8'h28, GAP);
    send_byte(0, 8'h0C, GAP);
    send_byte(0, 8'h06, GAP);
    send_byte(0, 8'h01, GAP);
    send_byte(0, 8'h80, GAP);
    send_byte(1, 8'h31, GAP);
    chk("init_four_bit", four_bit_mode, 1);
    chk("init_display_on", display_on, 1);
    chk("init_cursor", cursor, 1);
    read_at(0, 8'h31, "init_ddram0");

    // Line 2 addressing and wrap from 31 to 0.
    send_byte(0, 8'hCF, GAP);
    send_byte(1, 8'h41, GAP);
    send_byte(1, 8'h42, GAP);
    read_at(31, 8'h41, "wrap_ddram31");
    read_at(0, 8'h42, "wrap_ddram0");
    chk("wrap_cursor", cursor, 1);

    // Short pulse is discarded without disturbing the nibble phase.
    v0 = valid_cnt;
    pulse(1, 4'h5, 8);
    repeat (4) @(negedge clk);
    chk("short_no_byte", valid_cnt - v0, 0);
    send_byte(1, 8'h41, GAP);
    chk("short_err", short_pulse_err, 1);
    chk("short_one_byte", valid_cnt - v0, 1);

    // Decrement mode wraps 0 to 31.
    send_byte(0, 8'h04, GAP);
    send_byte(0, 8'h80, GAP);
    send_byte(1, 8'h5A, GAP);
    read_at(0, 8'h5A, "dec_ddram0");
    chk("dec_cursor", cursor, 31);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      send_byte(1'($urandom), rb, GAP);
    end
    check_ram();
    chk("short_err_sticky", short_pulse_err, 1);
    chk("busy_err_clean", busy_err, 0);

    // Return to 4-bit mode if random traffic left the bus in 8-bit mode.
    if (!m_four) send_byte(0, 8'h20, GAP);

    // Clear followed by a late byte, then by an early one.
    send_byte(0, 8'h01, CLR + 10);
    send_byte(1, 8'h51, GAP);
    chk("busy_err_after_wait", busy_err, 0);
    send_byte(0, 8'h01, CLR / 3);
    send_byte(1, 8'h52, GAP);
`ifdef LCD_RX_BUSY_CHECK_EN
    chk("busy_at_byte", last_busy, 1);
    chk("busy_err_set", busy_err, 1);
`else
    chk("busy_at_byte", last_busy, 0);
    chk("busy_err_set", busy_err, 0);
`endif
    check_ram();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_hd44780_rx.md
# lcd_hd44780_rx

- Receive-side model of the HD44780-compatible character LCD, driven by the chronometer's 4-bit LCD write interface (RS, E, DB[7:4], RW tied low).
- Samples the bus in the 50 MHz domain, times E pulses and assembles nibbles into instruction/data bytes.
- Executes the instruction subset the chronometer uses, keeping a 2×16 DDRAM image readable through a side port.
- Serves as the responder for the LCD driver in simulation and as an on-board bus monitor, with sticky protocol-error flags.

## Interface

Parameters:
- MIN_E_HIGH, 12, minimum E-high width in qzt_clk cycles (240 ns); shorter pulses are rejected
- EXEC_CYCLES, 2000, busy time after an ordinary instruction or data byte (40 µs)
- CLEAR_CYCLES, 82000, busy time after clear/return-home (1.64 ms)

Ports:
- qzt_clk  in  1  50 MHz clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- lcd_flags  in  2  {RS, E} from the LCD bus, asynchronous
- lcd_data  in  4  DB[7:4] from the LCD bus, asynchronous
- rd_addr  in  5  DDRAM read index: 0–15 = line 1, 16–31 = line 2
- rd_char  out  8  DDRAM[rd_addr], combinational read
- cursor  out  5  current DDRAM index
- display_on  out  1  D bit of the last display-control instruction
- four_bit_mode  out  1  interface width: 1 = 4-bit, 0 = 8-bit
- byte_valid  out  1  one-cycle pulse when a byte is accepted
- byte_rs  out  1  RS of the accepted byte; valid with byte_valid
- byte_out  out  8  accepted byte; valid with byte_valid
- busy  out  1  execution timer running
- short_pulse_err  out  1  sticky: an E pulse was shorter than MIN_E_HIGH
- busy_err  out  1  sticky: a byte completed while busy was high

## Operation

- **Input synchronizer.** lcd_flags and lcd_data pass through a 2-FF synchronizer.
- **E-high counter.** Counts cycles while the synchronized E is high, saturating at MIN_E_HIGH.
- **Falling edge of synchronized E.**
  - If the count is below MIN_E_HIGH: set short_pulse_err and discard the pulse; nibble phase is unchanged.
  - Otherwise: capture RS and DB from the last cycle E was high.
- **8-bit mode** (reset state): each accepted pulse forms byte = {DB, 4'hF}, because DB[3:0] is tied high on the board.
- **4-bit mode.**
  - First accepted pulse is the high nibble; the second is the low nibble, with RS taken from the second.
  - Phase toggles high → low → high.
- **Byte execution**, applied on the byte_valid cycle:
  - RS=1, data: DDRAM[cursor] ← byte. cursor ± 1 according to I/D, modulo 32 (31 → 0 and 0 → 31).
  - 0x01, clear: all DDRAM ← 0x20, cursor ← 0, I/D ← 1.
  - 0x02–0x03, return home: cursor ← 0.
  - 0x04–0x07, entry mode: I/D ← bit1; the shift bit is ignored.
  - 0x08–0x0F, display control: display_on ← bit2.
  - 0x10–0x1F, cursor/display shift: no effect.
  - 0x20–0x3F, function set: four_bit_mode ← ~bit4, and phase ← high.
  - 0x40–0x7F, CGRAM address: no effect.
  - 0x80–0xFF, DDRAM address: cursor ← {byte[6], byte[3:0]}.
- **Reset values.**
  - DDRAM all 0x20; cursor 0; I/D 1.
  - display_on 0; four_bit_mode 0; phase high.
  - byte_valid 0, byte_rs 0, byte_out 0x00.
  - busy 0; both error flags 0.
- **Error flags.** Cleared only by rst_n.
- **Reset mid-operation.** Any partial nibble pair is lost.

## Timing

- **Latency.**
  - Raw E falling at the pin → byte_valid: 4 qzt_clk cycles (2 sync, 1 edge detect, 1 register).
  - DDRAM, cursor and mode updates are visible on the cycle after byte_valid.
- **Minimum spacing.** Back-to-back pulses need E low for ≥ 2 cycles; the block is not specified for shorter low times.
- **Busy timer.**
  - Loads on byte_valid: CLEAR_CYCLES for 0x01–0x03 with RS=0, otherwise EXEC_CYCLES.
  - Counts down; busy is high while the count is nonzero.
- **Byte completed while busy:**
  - busy_err is set.
  - The byte is still executed.
  - The timer reloads.
- **Short-pulse rejection.** Short pulses never produce byte_valid.

## Configuration

- **LCD_RX_BUSY_CHECK_EN**
  - Defined: busy timer and busy_err are implemented as above.
  - Undefined: no timer is compiled in; busy and busy_err are tied to 0, and EXEC_CYCLES and CLEAR_CYCLES are unused.

## Test plan

- **Reset state:** Assert rst_n low mid-pulse → all outputs at reset values; rd_char = 0x20 for all 32 addresses.
- **Init and data write:**
  - Stimulus: 8-bit nibbles 0x3, 0x3, 0x3, 0x2, then 4-bit bytes 0x28, 0x0C, 0x06, 0x01, 0x80, then data 0x31.
  - Required: four_bit_mode = 1, display_on = 1, DDRAM[0] = 0x31, cursor = 1.
- **Line-2 addressing and wrap:**
  - Stimulus: command 0xCF, write 'A', write 'B'.
  - Required: DDRAM[31] = 0x41, DDRAM[0] = 0x42, cursor = 1.
- **Short pulse:**
  - Stimulus: E high for 8 cycles carrying nibble 0x5, then a valid pair 0x4/0x1.
  - Required: short_pulse_err = 1; exactly one byte_valid, with byte_out = 0x41.
- **Busy violation (macro defined):**
  - Stimulus: 0x01, then a data byte 1000 cycles later.
  - Required: busy = 1 at that byte, and busy_err = 1.
  - Required: a byte issued ≥ CLEAR_CYCLES + 4 cycles after clear leaves busy_err = 0.
- **Decrement mode:**
  - Stimulus: entry mode 0x04, cursor set to 0x80, write 'Z'.
  - Required: DDRAM[0] = 0x5A, cursor = 31.
